// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the memory-stage access sequencer.
// The optional access timeout is enabled with the PIPE_MEM_TIMEOUT_EN macro.
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_e;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam int          CNT_W        = 8;

endpackage : pipe_mem_pkg

// File: rtl/pipe_mem_seq_if.sv
// Bundles the EX/MEM request side, the data-memory handshake and the
// pipeline-control outputs of the memory-stage sequencer.
interface pipe_mem_seq_if;

    logic        m_load;
    logic        m_store;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        mw_bubble;
    logic [31:0] mmo;
    logic        mem_err;

    // Pipeline and memory side: drives requests and completions.
    modport master (
        output m_load, m_store, maddr, mdata, mem_ready, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, mw_bubble, mmo, mem_err
    );

    // Sequencer side.
    modport slave (
        input  m_load, m_store, maddr, mdata, mem_ready, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, mw_bubble, mmo, mem_err
    );

endinterface : pipe_mem_seq_if

// File: rtl/pipe_mem_timer.sv
// Access watchdog: counts ACCESS cycles without completion and flags the
// cycle in which the count reaches the limit. Used only with PIPE_MEM_TIMEOUT_EN.
module pipe_mem_timer
    import pipe_mem_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Fires in the cycle whose increment would make the count equal the limit.
    assign expired = enable && (count_q == limit - 1'b1);

endmodule : pipe_mem_timer

// File: rtl/pipe_mem_seq.sv
// Memory-stage sequencer: converts a single-cycle load/store into a req/ready
// access, stalling upstream and bubbling MEM/WB meanwhile. Macro: PIPE_MEM_TIMEOUT_EN.
module pipe_mem_seq
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clock,
    input  logic          reset,
    pipe_mem_seq_if.slave bus
);

    mem_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        access_req;

    assign access_req = bus.m_load || bus.m_store;

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic timer_clear;
    logic timer_en;
    logic timed_out;
    logic err_q, err_d;

    assign timer_clear = (state_q == ST_IDLE) && access_req;
    assign timer_en    = (state_q == ST_ACCESS) && !bus.mem_ready;

    pipe_mem_timer u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_en),
        .limit   (TIMEOUT_LIMIT),
        .expired (timed_out)
    );
`else
    logic [CNT_W-1:0] unused_limit;
    assign unused_limit = CNT_W'(TIMEOUT_CYCLES);
`endif

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        bus.stall     = 1'b0;
        bus.mw_bubble = 1'b0;
`ifdef PIPE_MEM_TIMEOUT_EN
        err_d         = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access_req) begin
                    bus.stall     = 1'b1;
                    bus.mw_bubble = 1'b1;
                    addr_d        = bus.maddr;
                    wdata_d       = bus.mdata;
                    we_d          = bus.m_store;
                    req_d         = 1'b1;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.stall     = 1'b1;
                bus.mw_bubble = 1'b1;
                if (bus.mem_ready) begin
                    if (!we_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ST_DONE;
`ifdef PIPE_MEM_TIMEOUT_EN
                end else if (timed_out) begin
                    rdata_d = TIMEOUT_DATA;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef PIPE_MEM_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.mem_err = err_q;
`else
    assign bus.mem_err = 1'b0;
`endif

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mmo       = rdata_q;

endmodule : pipe_mem_seq

// File: tb/tb_pipe_mem_seq.sv
// Directed self-checking bench for pipe_mem_seq; the timeout cases run only
// when PIPE_MEM_TIMEOUT_EN is defined (bench uses TIMEOUT_CYCLES = 4).
module tb_pipe_mem_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    pipe_mem_seq_if bus ();

    pipe_mem_seq #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One complete access starting in IDLE; mem_ready is raised in the
    // ready_at-th ACCESS cycle. Ends one cycle after DONE, back in IDLE.
    task automatic do_access(input string tag, input logic st, input logic [31:0] a,
                             input logic [31:0] d, input int ready_at,
                             input logic [31:0] rd, input logic [31:0] exp_mmo);
        int stalls;
        bus.m_load  = !st;
        bus.m_store = st;
        bus.maddr   = a;
        bus.mdata   = d;
        #1;
        check({tag, ".idle_stall"}, 32'(bus.stall), 32'd1);
        check({tag, ".idle_bubble"}, 32'(bus.mw_bubble), 32'd1);
        check({tag, ".idle_req"}, 32'(bus.mem_req), 32'd0);
        stalls = 1;
        tick();
        for (int k = 1; k <= ready_at; k++) begin
            check({tag, ".acc_req"}, 32'(bus.mem_req), 32'd1);
            check({tag, ".acc_we"}, 32'(bus.mem_we), 32'(st));
            check({tag, ".acc_addr"}, bus.mem_addr, a);
            check({tag, ".acc_wdata"}, bus.mem_wdata, d);
            check({tag, ".acc_bubble"}, 32'(bus.mw_bubble), 32'd1);
            if (bus.stall) stalls++;
            if (k == ready_at) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd;
            end
            tick();
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0BAD_0BAD;
        bus.m_load    = 1'b0;
        bus.m_store   = 1'b0;
        #1;
        check({tag, ".done_stall"}, 32'(bus.stall), 32'd0);
        check({tag, ".done_bubble"}, 32'(bus.mw_bubble), 32'd0);
        check({tag, ".done_req"}, 32'(bus.mem_req), 32'd0);
        check({tag, ".done_we"}, 32'(bus.mem_we), 32'd0);
        check({tag, ".done_mmo"}, bus.mmo, exp_mmo);
        check({tag, ".done_err"}, 32'(bus.mem_err), 32'd0);
        check({tag, ".stall_cycles"}, 32'(stalls), 32'(ready_at + 1));
        tick();
    endtask

    initial begin
        bus.m_load    = 1'b0;
        bus.m_store   = 1'b0;
        bus.maddr     = '0;
        bus.mdata     = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        // Reset state
        #2;
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_mmo", bus.mmo, 32'd0);
        check("rst_err", 32'(bus.mem_err), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Non-memory instruction: no stall, no request
        #1;
        check("nomem_stall", 32'(bus.stall), 32'd0);
        tick();
        check("nomem_req", 32'(bus.mem_req), 32'd0);

        // Load 0x40, ready in first ACCESS cycle
        do_access("load40", 1'b0, 32'h0000_0040, 32'h0, 1, 32'h1234_5678, 32'h1234_5678);

        // Store 0x80, ready in fourth ACCESS cycle; mmo keeps previous load data
        do_access("store80", 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 4, 32'h5555_AAAA, 32'h1234_5678);

        // Back-to-back loads with one IDLE cycle between DONEs
        do_access("ld_a", 1'b0, 32'h0000_0100, 32'h0, 1, 32'hA5A5_0001, 32'hA5A5_0001);
        check("b2b_gap_req", 32'(bus.mem_req), 32'd0);
        do_access("ld_b", 1'b0, 32'h0000_0104, 32'h0, 2, 32'hA5A5_0002, 32'hA5A5_0002);

        // mem_ready in IDLE is ignored
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_0000;
        tick();
        bus.mem_ready = 1'b0;
        check("idle_rdy_mmo", bus.mmo, 32'hA5A5_0002);
        check("idle_rdy_req", 32'(bus.mem_req), 32'd0);
        check("idle_rdy_stall", 32'(bus.stall), 32'd0);

        // Reset pulsed mid-ACCESS
        bus.m_load = 1'b1;
        bus.maddr  = 32'h0000_0200;
        tick();
        check("mid_rst_pre_req", 32'(bus.mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(bus.mem_req), 32'd0);
        check("mid_rst_mmo", bus.mmo, 32'd0);
        check("mid_rst_addr", bus.mem_addr, 32'd0);
        bus.m_load = 1'b0;
        #1;
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_ready = 1'b0;
        check("post_rst_mmo", bus.mmo, 32'd0);
        check("post_rst_req", 32'(bus.mem_req), 32'd0);
        check("post_rst_stall", 32'(bus.stall), 32'd0);

`ifdef PIPE_MEM_TIMEOUT_EN
        // No mem_ready: forced completion after 4 ACCESS cycles
        bus.m_load = 1'b1;
        bus.maddr  = 32'h0000_0300;
        tick();
        for (int k = 1; k <= 4; k++) begin
            check("to_acc_req", 32'(bus.mem_req), 32'd1);
            check("to_acc_err", 32'(bus.mem_err), 32'd0);
            tick();
        end
        bus.m_load = 1'b0;
        #1;
        check("to_done_req", 32'(bus.mem_req), 32'd0);
        check("to_done_mmo", bus.mmo, 32'hDEAD_BEEF);
        check("to_done_err", 32'(bus.mem_err), 32'd1);
        check("to_done_stall", 32'(bus.stall), 32'd0);
        tick();
        check("to_after_err", 32'(bus.mem_err), 32'd0);
        check("to_after_mmo", bus.mmo, 32'hDEAD_BEEF);

        // Ready in the 4th ACCESS cycle beats the timeout
        do_access("to_race", 1'b0, 32'h0000_0304, 32'h0, 4, 32'h0102_0304, 32'h0102_0304);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_mem_seq
